// File: rtl/lfsr_rng_arbiter.sv
// Shared 32-bit Fibonacci LFSR random-number server: seeding, warm-up sequencing,
// and round-robin delivery of one distinct word per grant to N_REQ requesters.
module lfsr_rng_arbiter #(
    parameter int          N_REQ        = 4,
    parameter int          WARMUP       = 32,
    parameter logic [31:0] DEFAULT_SEED = 32'hACE1_0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_valid,
    input  logic [31:0]      seed,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [31:0]      rnd,
    output logic             ready
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {S_WARM, S_RUN} state_t;

    state_t            state, state_n;
    logic [31:0]       lfsr, lfsr_n, lfsr_step, rnd_n;
    logic [7:0]        cnt, cnt_n;
    logic [PW-1:0]     rr_ptr, rr_ptr_n, win_idx, cand;
    logic              win_found;
    logic [N_REQ-1:0]  elig, gnt_n;

    assign lfsr_step = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

    // A requester granted last cycle sits out one round so a held req is not double-served.
    for (genvar i = 0; i < N_REQ; i++) begin : g_elig
        assign elig[i] = req[i] & ~gnt[i];
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PW'((int'(rr_ptr) + k) % N_REQ);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_n  = state;
        lfsr_n   = lfsr;
        cnt_n    = cnt;
        rr_ptr_n = rr_ptr;
        gnt_n    = '0;
        rnd_n    = rnd;
        if (seed_valid) begin
            lfsr_n  = (seed == 32'h0) ? DEFAULT_SEED : seed;
            state_n = S_WARM;
            cnt_n   = 8'(WARMUP);
        end else begin
            case (state)
                S_WARM: begin
                    if (cnt == 8'd0) begin
                        state_n = S_RUN;
                    end else begin
                        lfsr_n = lfsr_step;
                        cnt_n  = cnt - 8'd1;
                    end
                end
                S_RUN: begin
                    lfsr_n = lfsr_step;
                    if (win_found) begin
                        gnt_n[win_idx] = 1'b1;
                        rnd_n          = lfsr;
                        rr_ptr_n       = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
                    end
                end
                default: state_n = S_WARM;
            endcase
            // All-zero state is a fixed point of the LFSR; recover rather than lock up.
            if (lfsr == 32'h0) lfsr_n = DEFAULT_SEED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_WARM;
            lfsr   <= DEFAULT_SEED;
            cnt    <= 8'(WARMUP);
            rr_ptr <= '0;
            gnt    <= '0;
            rnd    <= '0;
            ready  <= 1'b0;
        end else begin
            state  <= state_n;
            lfsr   <= lfsr_n;
            cnt    <= cnt_n;
            rr_ptr <= rr_ptr_n;
            gnt    <= gnt_n;
            rnd    <= rnd_n;
            ready  <= (state_n == S_RUN);
        end
    end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Bench for lfsr_rng_arbiter: vector table on a WARMUP=0 instance, scoreboarded
// multi-cycle sequences (warm-up, rotation, reseed, async reset) on a default instance.
module tb_lfsr_rng_arbiter;
    localparam int          N     = 4;
    localparam logic [31:0] DSEED = 32'hACE1_0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sv = 1'b0, sv0 = 1'b0;
    logic [31:0] sd = '0, sd0 = '0;
    logic [N-1:0] rq = '0, rq0 = '0;
    logic [N-1:0] gnt, gnt0;
    logic [31:0] rnd, rnd0;
    logic rdy, rdy0;

    always #5 clk = ~clk;

    lfsr_rng_arbiter #(.N_REQ(N), .WARMUP(32), .DEFAULT_SEED(DSEED)) dut (
        .clk(clk), .rst_n(rst_n), .seed_valid(sv), .seed(sd), .req(rq),
        .gnt(gnt), .rnd(rnd), .ready(rdy));

    lfsr_rng_arbiter #(.N_REQ(N), .WARMUP(0), .DEFAULT_SEED(DSEED)) dut0 (
        .clk(clk), .rst_n(rst_n), .seed_valid(sv0), .seed(sd0), .req(rq0),
        .gnt(gnt0), .rnd(rnd0), .ready(rdy0));

    int n_chk = 0;
    int n_fail = 0;

    typedef struct { logic [N-1:0] gnt; logic [31:0] rnd; logic rdy; string tag; } exp_t;
    exp_t sbq[$];

    typedef struct { logic sv; logic [31:0] seed; logic [N-1:0] req;
                     logic [N-1:0] gnt; logic [31:0] rnd; logic rdy; } vec_t;
    vec_t vt[10];

    function automatic logic [31:0] lstep(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [31:0] ladv(input logic [31:0] s, input int n);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < n; i++) t = lstep(t);
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Push the expectation for the coming edge, then pop and compare just after it.
    task automatic step(input bit sel, input logic [N-1:0] eg, input logic [31:0] er,
                        input logic erdy, input string tag);
        exp_t e;
        e.gnt = eg; e.rnd = er; e.rdy = erdy; e.tag = tag;
        sbq.push_back(e);
        @(posedge clk); #1;
        e = sbq.pop_front();
        chk({e.tag, " gnt"},   32'(sel ? gnt0 : gnt), 32'(e.gnt));
        chk({e.tag, " rnd"},   sel ? rnd0 : rnd, e.rnd);
        chk({e.tag, " ready"}, 32'(sel ? rdy0 : rdy), 32'(e.rdy));
    endtask

    // Reset release to RUN, then full contention; identical after every reset.
    task automatic run_boot(output logic [31:0] m_out, output logic [31:0] last);
        int n;
        logic [31:0] m;
        logic [N-1:0] prev;
        n = 0;
        rq = '0;
        while (n < 60) begin
            @(posedge clk); #1;
            n++;
            chk("boot gnt idle", 32'(gnt), 32'h0);
            if (rdy) break;
        end
        chk("boot ready edges", 32'(n), 32'd33);
        m = ladv(DSEED, 32);
        prev = '0;
        rq = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, N'(1 << (k % N)), m, 1'b1, "rotate");
            chk("rotate onehot", 32'($countones(gnt) <= 1), 32'd1);
            chk("rotate norepeat", 32'(gnt & prev), 32'h0);
            prev = gnt;
            last = m;
            m = lstep(m);
        end
        rq = '0;
        m_out = m;
    endtask

    initial begin
        logic [31:0] m, last, r, last2;
        vt[0] = '{1'b1, 32'h1,      4'b0011, 4'b0000, 32'h0,         1'b0};
        vt[1] = '{1'b0, 32'h0,      4'b0011, 4'b0000, 32'h0,         1'b1};
        vt[2] = '{1'b0, 32'h0,      4'b0011, 4'b0001, 32'h1,         1'b1};
        vt[3] = '{1'b0, 32'h0,      4'b0011, 4'b0010, 32'h3,         1'b1};
        vt[4] = '{1'b0, 32'h0,      4'b0011, 4'b0001, 32'h6,         1'b1};
        vt[5] = '{1'b0, 32'h0,      4'b0011, 4'b0010, 32'hD,         1'b1};
        vt[6] = '{1'b1, 32'h0,      4'b0011, 4'b0000, 32'hD,         1'b0};
        vt[7] = '{1'b0, 32'h0,      4'b0001, 4'b0000, 32'hD,         1'b1};
        vt[8] = '{1'b0, 32'h0,      4'b0001, 4'b0001, 32'hACE1_0001, 1'b1};
        vt[9] = '{1'b0, 32'h0,      4'b0000, 4'b0000, 32'hACE1_0001, 1'b1};

        #1;
        chk("reset gnt",   32'(gnt), 32'h0);
        chk("reset rnd",   rnd, 32'h0);
        chk("reset ready", 32'(rdy), 32'h0);
        chk("reset gnt0",  32'(gnt0), 32'h0);
        #21 rst_n = 1'b1;

        // WARMUP=0 instance: seed=1 sequence, then zero-seed substitution.
        for (int i = 0; i < 10; i++) begin
            sv0 = vt[i].sv; sd0 = vt[i].seed; rq0 = vt[i].req;
            step(1'b1, vt[i].gnt, vt[i].rnd, vt[i].rdy, $sformatf("vec%0d", i));
        end
        sv0 = 1'b0; rq0 = '0;

        // Fresh boot of the default instance.
        #2 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        run_boot(m, last);

        // Reseed collides with a pending grant: seed wins, then full warm-up.
        sv = 1'b1; sd = 32'h1234_5678; rq = 4'b0100;
        step(1'b0, 4'b0000, last, 1'b0, "seed wins");
        sv = 1'b0;
        for (int i = 0; i < 32; i++) step(1'b0, 4'b0000, last, 1'b0, "rewarm");
        step(1'b0, 4'b0000, last, 1'b1, "rewarm end");
        r = ladv(32'h1234_5678, 32);
        step(1'b0, 4'b0100, r, 1'b1, "reseed first");
        rq = '0;
        r = lstep(r);
        step(1'b0, 4'b0000, ladv(32'h1234_5678, 32), 1'b1, "reseed hold");
        r = lstep(r);
        rq = 4'b1111;
        step(1'b0, 4'b1000, r, 1'b1, "wrap grant3");

        // Async reset in the middle of a grant cycle.
        #2 rst_n = 1'b0;
        #1;
        chk("async gnt",   32'(gnt), 32'h0);
        chk("async rnd",   rnd, 32'h0);
        chk("async ready", 32'(rdy), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        run_boot(m, last2);
        chk("replay last rnd", last2, last);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
